// File: rtl/conv_controller.sv
// Control FSM for the 3x3 binary-convolution datapath: sequences weight/input loading,
// row priming, then per output row a column scan, pipeline drain and a single row write.
module conv_controller #(
   parameter int FILL_ROWS = 2,
   parameter int DRAIN_CYC = 3
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic       dut_run,
   input  logic       dut_busy,
   input  logic       last_col_next,
   input  logic       last_row_flag,
   output logic       dut_busy_toggle,
   output logic       rst_dut_wmem_read_address,
   output logic       str_weights_dims,
   output logic       str_weights_data,
   output logic       str_input_nrows,
   output logic       str_input_ncols,
   output logic       incr_raddr_enable,
   output logic       pln_input_row_enable,
   output logic       incr_row_enable,
   output logic       rst_row_counter,
   output logic       incr_col_enable,
   output logic       rst_col_counter,
   output logic       update_d_in,
   output logic       toggle_conv_go_flag,
   output logic       str_temp_to_write,
   output logic       rst_output_row_temp,
   output logic       incr_output_addr,
   output logic [3:0] dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_START = 4'd1,
      S_WDIM  = 4'd2,
      S_WDAT  = 4'd3,
      S_FILL  = 4'd4,
      S_ROW   = 4'd5,
      S_SCAN  = 4'd6,
      S_DRAIN = 4'd7,
      S_WRITE = 4'd8,
      S_CLR   = 4'd9,
      S_DONE  = 4'd10
   } state_t;

   localparam logic [7:0] FILL_LAST  = 8'(FILL_ROWS - 1);
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] fill_cnt;
   logic [7:0] drain_cnt;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Counters run only while their state is active and sit at zero otherwise,
   // so each FILL/DRAIN visit starts counting from zero.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         fill_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         fill_cnt  <= (state == S_FILL)  ? fill_cnt + 8'd1  : '0;
         drain_cnt <= (state == S_DRAIN) ? drain_cnt + 8'd1 : '0;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (dut_run && !dut_busy) state_next = S_START;
         S_START: state_next = S_WDIM;
         S_WDIM:  state_next = S_WDAT;
         S_WDAT:  state_next = S_FILL;
         S_FILL:  if (fill_cnt == FILL_LAST) state_next = S_ROW;
         S_ROW:   state_next = S_SCAN;
         S_SCAN:  if (last_col_next) state_next = S_DRAIN;
         S_DRAIN: if (drain_cnt == DRAIN_LAST) state_next = S_WRITE;
         S_WRITE: state_next = last_row_flag ? S_DONE : S_CLR;
         S_CLR:   state_next = S_ROW;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      dut_busy_toggle           = 1'b0;
      rst_dut_wmem_read_address = 1'b0;
      str_weights_dims          = 1'b0;
      str_weights_data          = 1'b0;
      str_input_nrows           = 1'b0;
      str_input_ncols           = 1'b0;
      incr_raddr_enable         = 1'b0;
      pln_input_row_enable      = 1'b0;
      incr_row_enable           = 1'b0;
      rst_row_counter           = 1'b0;
      incr_col_enable           = 1'b0;
      rst_col_counter           = 1'b0;
      update_d_in               = 1'b0;
      toggle_conv_go_flag       = 1'b0;
      str_temp_to_write         = 1'b0;
      rst_output_row_temp       = 1'b0;
      incr_output_addr          = 1'b0;
      case (state)
         S_START: begin
            dut_busy_toggle     = 1'b1;
            rst_row_counter     = 1'b1;
            rst_col_counter     = 1'b1;
            rst_output_row_temp = 1'b1;
            incr_raddr_enable   = 1'b1;
         end
         S_WDIM: begin
            str_weights_dims  = 1'b1;
            str_input_nrows   = 1'b1;
            incr_raddr_enable = 1'b1;
         end
         S_WDAT: begin
            rst_dut_wmem_read_address = 1'b1;
            str_weights_data          = 1'b1;
            str_input_ncols           = 1'b1;
            incr_raddr_enable         = 1'b1;
         end
         S_FILL: begin
            rst_dut_wmem_read_address = 1'b1;
            pln_input_row_enable      = 1'b1;
            incr_row_enable           = 1'b1;
            incr_raddr_enable         = 1'b1;
         end
         S_ROW: begin
            rst_dut_wmem_read_address = 1'b1;
            pln_input_row_enable      = 1'b1;
            incr_row_enable           = 1'b1;
            incr_raddr_enable         = 1'b1;
            toggle_conv_go_flag       = 1'b1;
         end
         S_SCAN: begin
            rst_dut_wmem_read_address = 1'b1;
            update_d_in               = 1'b1;
            incr_col_enable           = 1'b1;
         end
         S_DRAIN: begin
            rst_dut_wmem_read_address = 1'b1;
         end
         S_WRITE: begin
            rst_dut_wmem_read_address = 1'b1;
            str_temp_to_write         = 1'b1;
            incr_output_addr          = 1'b1;
            rst_col_counter           = 1'b1;
            toggle_conv_go_flag       = 1'b1;
         end
         // The accumulator is cleared only after WRITE has copied it out.
         S_CLR: begin
            rst_dut_wmem_read_address = 1'b1;
            rst_output_row_temp       = 1'b1;
         end
         S_DONE: begin
            rst_dut_wmem_read_address = 1'b1;
            dut_busy_toggle           = 1'b1;
         end
         default: ;
      endcase
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_conv_controller.sv
// Bench for conv_controller: models the datapath counters/busy flag and checks
// per-cycle output traces and per-job pulse counts against a scoreboard queue.
module tb_conv_controller;

   logic clk;
   logic reset_b;
   logic dut_run;
   logic dut_busy;
   logic last_col_next;
   logic last_row_flag;
   logic dut_busy_toggle, rst_dut_wmem_read_address, str_weights_dims, str_weights_data;
   logic str_input_nrows, str_input_ncols, incr_raddr_enable, pln_input_row_enable;
   logic incr_row_enable, rst_row_counter, incr_col_enable, rst_col_counter, update_d_in;
   logic toggle_conv_go_flag, str_temp_to_write, rst_output_row_temp, incr_output_addr;
   logic [3:0] dbg_state;

   conv_controller #(.FILL_ROWS(2), .DRAIN_CYC(3)) dut (
      .clk                       (clk),
      .reset_b                   (reset_b),
      .dut_run                   (dut_run),
      .dut_busy                  (dut_busy),
      .last_col_next             (last_col_next),
      .last_row_flag             (last_row_flag),
      .dut_busy_toggle           (dut_busy_toggle),
      .rst_dut_wmem_read_address (rst_dut_wmem_read_address),
      .str_weights_dims          (str_weights_dims),
      .str_weights_data          (str_weights_data),
      .str_input_nrows           (str_input_nrows),
      .str_input_ncols           (str_input_ncols),
      .incr_raddr_enable         (incr_raddr_enable),
      .pln_input_row_enable      (pln_input_row_enable),
      .incr_row_enable           (incr_row_enable),
      .rst_row_counter           (rst_row_counter),
      .incr_col_enable           (incr_col_enable),
      .rst_col_counter           (rst_col_counter),
      .update_d_in               (update_d_in),
      .toggle_conv_go_flag       (toggle_conv_go_flag),
      .str_temp_to_write         (str_temp_to_write),
      .rst_output_row_temp       (rst_output_row_temp),
      .incr_output_addr          (incr_output_addr),
      .dbg_state                 (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // output vector bit positions
   localparam int B_BT = 16, B_WA = 15, B_WDIM = 14, B_WDAT = 13, B_NR = 12, B_NC = 11;
   localparam int B_RA = 10, B_PLN = 9, B_IROW = 8, B_RROW = 7, B_ICOL = 6, B_RCOL = 5;
   localparam int B_UPD = 4, B_GO = 3, B_TMP = 2, B_ROUT = 1, B_OADDR = 0;
   localparam logic [16:0] ONE = 17'd1;

   localparam logic [16:0] O_IDLE  = '0;
   localparam logic [16:0] O_START = (ONE << B_BT) | (ONE << B_RA) | (ONE << B_RROW) |
                                     (ONE << B_RCOL) | (ONE << B_ROUT);
   localparam logic [16:0] O_WDIM  = (ONE << B_WDIM) | (ONE << B_NR) | (ONE << B_RA);
   localparam logic [16:0] O_WDAT  = (ONE << B_WA) | (ONE << B_WDAT) | (ONE << B_NC) | (ONE << B_RA);
   localparam logic [16:0] O_FILL  = (ONE << B_WA) | (ONE << B_PLN) | (ONE << B_IROW) | (ONE << B_RA);
   localparam logic [16:0] O_ROW   = O_FILL | (ONE << B_GO);
   localparam logic [16:0] O_SCAN  = (ONE << B_WA) | (ONE << B_UPD) | (ONE << B_ICOL);
   localparam logic [16:0] O_DRAIN = (ONE << B_WA);
   localparam logic [16:0] O_WRITE = (ONE << B_WA) | (ONE << B_TMP) | (ONE << B_OADDR) |
                                     (ONE << B_RCOL) | (ONE << B_GO);
   localparam logic [16:0] O_DONE  = (ONE << B_WA) | (ONE << B_BT);

   logic [16:0] out_vec;
   assign out_vec = {dut_busy_toggle, rst_dut_wmem_read_address, str_weights_dims,
                     str_weights_data, str_input_nrows, str_input_ncols, incr_raddr_enable,
                     pln_input_row_enable, incr_row_enable, rst_row_counter, incr_col_enable,
                     rst_col_counter, update_d_in, toggle_conv_go_flag, str_temp_to_write,
                     rst_output_row_temp, incr_output_addr};

   // datapath model: busy TFF, row and column counters
   int nrows, ncols, row_cnt, col_cnt;
   logic busy_q;
   always @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         busy_q  <= 1'b0;
         row_cnt <= 0;
         col_cnt <= 0;
      end else begin
         if (dut_busy_toggle) busy_q <= ~busy_q;
         if (rst_row_counter) row_cnt <= 0;
         else if (incr_row_enable) row_cnt <= row_cnt + 1;
         if (rst_col_counter) col_cnt <= 0;
         else if (incr_col_enable) col_cnt <= col_cnt + 1;
      end
   end
   assign dut_busy      = busy_q;
   assign last_col_next = (col_cnt == ncols - 1);
   assign last_row_flag = (row_cnt == nrows);

   // pulse counters
   int c_write, c_raddr, c_scan, c_bt, c_go, c_oaddr, c_pair;
   logic prev_tmp;
   initial begin
      c_write = 0; c_raddr = 0; c_scan = 0; c_bt = 0; c_go = 0; c_oaddr = 0; c_pair = 0;
      prev_tmp = 1'b0;
   end
   always @(negedge clk) begin
      if (reset_b) begin
         c_write <= c_write + int'(str_temp_to_write);
         c_raddr <= c_raddr + int'(incr_raddr_enable);
         c_scan  <= c_scan + int'(update_d_in);
         c_bt    <= c_bt + int'(dut_busy_toggle);
         c_go    <= c_go + int'(toggle_conv_go_flag);
         c_oaddr <= c_oaddr + int'(incr_output_addr);
         c_pair  <= c_pair + int'(prev_tmp && rst_output_row_temp);
         prev_tmp <= str_temp_to_write;
      end else begin
         prev_tmp <= 1'b0;
      end
   end

   // scoreboard
   logic [31:0] exp_q[$];
   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      bit done = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (!dut_busy && out_vec == O_IDLE) begin
            done = 1;
            break;
         end
      end
      check({tag, "_idle_timeout"}, 32'(done), 32'd1);
      @(negedge clk);
   endtask

   task automatic run_counts(input int r, input int c, input string tag);
      int s_write, s_raddr, s_scan, s_bt, s_go, s_oaddr, s_pair;
      nrows = r;
      ncols = c;
      @(negedge clk);
      s_write = c_write; s_raddr = c_raddr; s_scan = c_scan; s_bt = c_bt;
      s_go = c_go; s_oaddr = c_oaddr; s_pair = c_pair;
      exp_q.push_back(32'(r - 2));
      exp_q.push_back(32'(r + 3));
      exp_q.push_back(32'(c * (r - 2)));
      exp_q.push_back(32'd2);
      exp_q.push_back(32'(2 * (r - 2)));
      exp_q.push_back(32'(r - 2));
      exp_q.push_back(32'(r - 3));
      dut_run = 1'b1;
      @(negedge clk);
      dut_run = 1'b0;
      wait_idle(tag);
      check({tag, "_writes"}, 32'(c_write - s_write), exp_q.pop_front());
      check({tag, "_raddr"},  32'(c_raddr - s_raddr), exp_q.pop_front());
      check({tag, "_scan"},   32'(c_scan - s_scan),   exp_q.pop_front());
      check({tag, "_busy_tg"},32'(c_bt - s_bt),       exp_q.pop_front());
      check({tag, "_go_tg"},  32'(c_go - s_go),       exp_q.pop_front());
      check({tag, "_oaddr"},  32'(c_oaddr - s_oaddr), exp_q.pop_front());
      check({tag, "_wr_clr"}, 32'(c_pair - s_pair),   exp_q.pop_front());
   endtask

   initial begin
      int s_bt, s_write;
      bit seen;
      reset_b = 1'b0;
      dut_run = 1'b0;
      nrows = 3;
      ncols = 3;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(out_vec), 32'(O_IDLE));
      check("reset_state", 32'(dbg_state), 32'd0);
      reset_b = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_outputs", 32'(out_vec), 32'(O_IDLE));

      // 3x3 job: full per-cycle output trace
      nrows = 3;
      ncols = 3;
      exp_q.push_back(32'(O_START)); exp_q.push_back(32'(O_WDIM)); exp_q.push_back(32'(O_WDAT));
      for (int i = 0; i < 2; i++) exp_q.push_back(32'(O_FILL));
      exp_q.push_back(32'(O_ROW));
      for (int i = 0; i < 3; i++) exp_q.push_back(32'(O_SCAN));
      for (int i = 0; i < 3; i++) exp_q.push_back(32'(O_DRAIN));
      exp_q.push_back(32'(O_WRITE)); exp_q.push_back(32'(O_DONE)); exp_q.push_back(32'(O_IDLE));
      dut_run = 1'b1;
      @(negedge clk);
      dut_run = 1'b0;
      for (int i = 0; exp_q.size() > 0; i++) begin
         check($sformatf("trace3x3_c%0d", i), 32'(out_vec), exp_q.pop_front());
         @(negedge clk);
      end
      check("trace3x3_busy_low", 32'(dut_busy), 32'd0);

      // count-based jobs
      run_counts(5, 5, "job5x5");
      run_counts(16, 16, "job16x16");
      run_counts(6, 9, "job6x9");

      // dut_run held high: no restart mid-job, restart 2 cycles after DONE
      nrows = 3;
      ncols = 3;
      @(negedge clk);
      s_bt = c_bt;
      s_write = c_write;
      dut_run = 1'b1;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_vec == O_DONE) begin
            seen = 1;
            break;
         end
      end
      check("b2b_done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      check("b2b_idle_after_done", 32'(out_vec), 32'(O_IDLE));
      @(negedge clk);
      check("b2b_restart", 32'(out_vec), 32'(O_START));
      dut_run = 1'b0;
      wait_idle("b2b");
      check("b2b_busy_tg", 32'(c_bt - s_bt), 32'd4);
      check("b2b_writes", 32'(c_write - s_write), 32'd2);

      // reset in the middle of a scan
      nrows = 5;
      ncols = 5;
      s_write = c_write;
      dut_run = 1'b1;
      @(negedge clk);
      dut_run = 1'b0;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (update_d_in) begin
            seen = 1;
            break;
         end
      end
      check("rst_scan_seen", 32'(seen), 32'd1);
      reset_b = 1'b0;
      #1;
      check("rst_mid_outputs", 32'(out_vec), 32'(O_IDLE));
      check("rst_mid_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      reset_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("rst_post_c%0d", i), 32'(out_vec), 32'(O_IDLE));
      end
      check("rst_no_write", 32'(c_write - s_write), 32'd0);
      check("rst_busy_low", 32'(dut_busy), 32'd0);

      // a fresh job after the abort runs normally
      run_counts(4, 7, "job4x7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
